alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised sequential ALU that follows the single-cycle 3-bit-op ALU. It adds registered results, a start/busy/done handshake, and iterative unsigned multiply (shift-add) and unsigned divide (restoring), one bit per cycle. It sits in the execute stage of the multicycle datapath. The controller holds operands and `alu_ctr` stable and waits for `done` before latching `alu_out` and `hi_out`.

## Interface
- `WORD_SIZE`, 32: operand and result width. Must be a power of two and at least 4.
- `clk`  in  1: rising-edge clock, the only clock.
- `reset`  in  1: synchronous, active-high. Sampled on `clk` rising edge.
- `start`  in  1: request an operation. Accepted only on an edge where `busy`=0.
- `alu_ctr`  in  4: operation select, sampled at accept.
- `R2`  in  WORD_SIZE: operand A (dividend / multiplicand), sampled at accept.
- `R3`  in  WORD_SIZE: operand B (divisor / multiplier / shift amount), sampled at accept.
- `alu_out`  out  WORD_SIZE: registered result; low word for MULU, quotient for DIVU.
- `hi_out`  out  WORD_SIZE: registered high word for MULU, remainder for DIVU, 0 for all other ops.
- `zero`  out  1: registered; 1 when `alu_out`==0.
- `div_zero`  out  1: registered; 1 when the last completed op was DIVU with `R3`==0.
- `busy`  out  1: an iterative op is in progress.
- `done`  out  1: one-cycle pulse. The result registers are valid from this cycle onward.

## Operation
- `alu_ctr` encodings:
  - 0000 AND
  - 0001 ADD (modulo 2^W, carry dropped)
  - 0010 SUB (A−B modulo 2^W)
  - 0011 XOR
  - 0100 NOR
  - 0101 OR
  - 0110 SLT (signed, result 0 or 1)
  - 0111 SLTU (unsigned)
  - 1000 SLL: A << B[log2(W)−1:0]
  - 1001 SRL: logical right shift
  - 1010 SRA: arithmetic right shift
  - 1100 MULU
  - 1101 DIVU
  - All other encodings: result 0, `hi_out` 0, completes as a single-cycle op.
- States: IDLE, MUL, DIV.
  - IDLE + `start` + single-cycle op: compute, load `alu_out`/`hi_out`/`zero`, clear `div_zero`, pulse `done`. Stay in IDLE.
  - IDLE + `start` + MULU: load multiplicand and multiplier, clear the 2W product accumulator, count=W, go to MUL.
  - IDLE + `start` + DIVU with B≠0: load the dividend shift register, clear the remainder, count=W, go to DIV.
  - IDLE + `start` + DIVU with B==0: single-cycle completion. `alu_out`=all ones, `hi_out`=A, `div_zero`=1, `done` pulses. Stay in IDLE.
  - MUL, each cycle: if the multiplier LSB is set, add the shifted multiplicand to the accumulator. Shift, count−1. When count reaches 0: write {hi,lo} to `hi_out`/`alu_out`, update `zero`, clear `div_zero`, pulse `done`, go to IDLE.
  - DIV, each cycle: shift {rem,dividend} left by 1. Trial-subtract B from rem (W+1-bit subtract). If no borrow, keep the difference and set the quotient bit. count−1. When count reaches 0: write quotient to `alu_out` and remainder to `hi_out`, update `zero`, clear `div_zero`, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored: no queueing, and in-flight operands are unaffected.
- Operand inputs may change freely after accept; internal copies are used.
- Result registers hold their value until the next completion.
- `zero` always reflects `alu_out` only, never `hi_out`.

## Timing
- Reset value of every output is 0: `alu_out`, `hi_out`, `zero`, `div_zero`, `busy`, `done`. State is IDLE and count is 0.
- Reset asserted mid MUL/DIV aborts the op on that edge. No `done` is produced, and the outputs go to 0.
- Reset has priority over `start` on the same edge.
- Single-cycle ops and DIVU-by-zero: `start` accepted at edge T. Results and `done`=1 are visible after T and held for exactly one cycle. `busy` stays 0.
- MULU/DIVU: `start` accepted at edge T.
  - `busy`=1 after edges T … T+W−1.
  - At edge T+W: `busy`→0, results loaded, `done`=1 for one cycle.
  - Latency is W cycles. A new `start` is accepted at edge T+W+1 at the earliest, i.e. on the `done` cycle.
- `busy` and `done` are never both 1.
- Back-to-back single-cycle ops can be accepted on consecutive edges. `done` then stays high continuously, one pulse per op.

## Test plan
- Reset, then SUB with R2=5, R3=5 → one cycle later `alu_out`=0, `zero`=1, `done` pulse, `busy` stays 0. Follow with SLT R2=0xFFFFFFFF, R3=1 → `alu_out`=1. Follow with SLTU on the same operands → `alu_out`=0.
- MULU R2=R3=0xFFFFFFFF (W=32) → `busy` high for 32 cycles, then `done` with `hi_out`=0xFFFFFFFE, `alu_out`=0x00000001. Also MULU 0×123 → `alu_out`=0, `zero`=1.
- DIVU R2=100, R3=7 → after 32 cycles `alu_out`=14, `hi_out`=2, `div_zero`=0. Also DIVU 3/9 → quotient 0, remainder 3, `zero`=1.
- DIVU R2=0x1234, R3=0 → `done` one cycle after accept, `alu_out`=0xFFFFFFFF, `hi_out`=0x1234, `div_zero`=1. The next ADD 1+1 clears `div_zero` and gives `alu_out`=2.
- During a MULU, pulse `start` with ADD and change R2/R3 at cycle 5 → ignored. The MULU result is unchanged and only one `done` appears.
- Assert `reset` at cycle 10 of a DIVU → all outputs 0 on the next cycle and no `done`. SRA 0x80000000 by 4 afterwards → `alu_out`=0xF8000000.

Source files
------------

// File: rtl/alu_multicycle.sv
// Sequential ALU: registered single-cycle ops plus iterative MULU (shift-add) and DIVU (restoring).
// Latency: 1 cycle for single-cycle ops and DIVU-by-zero; WORD_SIZE cycles for MULU/DIVU.
// Backpressure: start is accepted only while busy=0; starts seen while busy are dropped.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, alu_ctr    request and 4-bit op select, sampled at accept
//   R2, R3            operand A / operand B, sampled at accept
//   alu_out, hi_out   registered result low word / high word (remainder for DIVU)
//   zero, div_zero    alu_out==0 flag, last op was DIVU by zero
//   busy, done        iterative op in flight, one-cycle completion pulse
module alu_multicycle #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           alu_ctr,
  input  logic [WORD_SIZE-1:0] R2,
  input  logic [WORD_SIZE-1:0] R3,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] hi_out,
  output logic                 zero,
  output logic                 div_zero,
  output logic                 busy,
  output logic                 done
);

  localparam int W   = WORD_SIZE;
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;

  // Multiply datapath: multiplicand widens as it shifts left into the 2W accumulator.
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;

  // Divide datapath: dividend register doubles as the quotient shift register.
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   divisor_q, divisor_d;

  logic [W-1:0]   alu_out_q, alu_out_d;
  logic [W-1:0]   hi_out_q, hi_out_d;
  logic           zero_q, zero_d;
  logic           div_zero_q, div_zero_d;
  logic           done_q, done_d;

  logic [W-1:0]   single_res;
  logic [SHW-1:0] shamt;
  logic [2*W-1:0] mul_acc_nxt;
  logic [W:0]     div_rem_sh;
  logic [W:0]     div_diff;
  logic           div_qbit;
  logic [W-1:0]   div_rem_nxt;
  logic [W-1:0]   div_dvd_nxt;

  assign shamt = R3[SHW-1:0];

  // Combinational result for every op that completes in the accept cycle.
  always_comb begin
    single_res = '0;
    case (alu_ctr)
      OP_AND:  single_res = R2 & R3;
      OP_ADD:  single_res = R2 + R3;
      OP_SUB:  single_res = R2 - R3;
      OP_XOR:  single_res = R2 ^ R3;
      OP_NOR:  single_res = ~(R2 | R3);
      OP_OR:   single_res = R2 | R3;
      OP_SLT:  single_res = {{(W-1){1'b0}}, ($signed(R2) < $signed(R3))};
      OP_SLTU: single_res = {{(W-1){1'b0}}, (R2 < R3)};
      OP_SLL:  single_res = R2 << shamt;
      OP_SRL:  single_res = R2 >> shamt;
      OP_SRA:  single_res = $unsigned($signed(R2) >>> shamt);
      default: single_res = '0;
    endcase
  end

  // One iteration of each iterative algorithm.
  always_comb begin
    mul_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Shift {rem,dividend} left by one, then trial-subtract the divisor with one
    // guard bit; a clear MSB in the difference means no borrow.
    div_rem_sh  = {rem_q, dvd_q[W-1]};
    div_diff    = div_rem_sh - {1'b0, divisor_q};
    div_qbit    = ~div_diff[W];
    div_rem_nxt = div_qbit ? div_diff[W-1:0] : div_rem_sh[W-1:0];
    div_dvd_nxt = {dvd_q[W-2:0], div_qbit};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    alu_out_d  = alu_out_q;
    hi_out_d   = hi_out_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (alu_ctr)
            OP_MULU: begin
              mcand_d  = {{W{1'b0}}, R2};
              mplier_d = R3;
              acc_d    = '0;
              count_d  = CNT_FULL;
              state_d  = MUL;
            end
            OP_DIVU: begin
              if (R3 == '0) begin
                alu_out_d  = '1;
                hi_out_d   = R2;
                zero_d     = 1'b0;
                div_zero_d = 1'b1;
                done_d     = 1'b1;
              end else begin
                dvd_d     = R2;
                divisor_d = R3;
                rem_d     = '0;
                count_d   = CNT_FULL;
                state_d   = DIV;
              end
            end
            default: begin
              alu_out_d  = single_res;
              hi_out_d   = '0;
              zero_d     = (single_res == '0);
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
          endcase
        end
      end

      MUL: begin
        acc_d    = mul_acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          alu_out_d  = mul_acc_nxt[W-1:0];
          hi_out_d   = mul_acc_nxt[2*W-1:W];
          zero_d     = (mul_acc_nxt[W-1:0] == '0);
          div_zero_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      DIV: begin
        rem_d   = div_rem_nxt;
        dvd_d   = div_dvd_nxt;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          alu_out_d  = div_dvd_nxt;
          hi_out_d   = div_rem_nxt;
          zero_d     = (div_dvd_nxt == '0);
          div_zero_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      alu_out_q  <= '0;
      hi_out_q   <= '0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      alu_out_q  <= alu_out_d;
      hi_out_q   <= hi_out_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign hi_out   = hi_out_q;
  assign zero     = zero_q;
  assign div_zero = div_zero_q;
  assign done     = done_q;
  // Derived from the state register, so it drops on the same edge done rises.
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   alu_ctr;
  logic [W-1:0] R2, R3;
  logic [W-1:0] alu_out, hi_out;
  logic         zero, div_zero, busy, done;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         dz;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_multicycle #(.WORD_SIZE(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctr(alu_ctr),
    .R2(R2), .R3(R3), .alu_out(alu_out), .hi_out(hi_out),
    .zero(zero), .div_zero(div_zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the op table using plain arithmetic operators.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [2*W-1:0] p;
    logic [4:0] sh;
    sh = b[4:0];
    r  = '0;
    case (op)
      4'b0000: r.lo = a & b;
      4'b0001: r.lo = a + b;
      4'b0010: r.lo = a - b;
      4'b0011: r.lo = a ^ b;
      4'b0100: r.lo = ~(a | b);
      4'b0101: r.lo = a | b;
      4'b0110: r.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0111: r.lo = (a < b) ? 1 : 0;
      4'b1000: r.lo = a << sh;
      4'b1001: r.lo = a >> sh;
      4'b1010: r.lo = $unsigned($signed(a) >>> sh);
      4'b1100: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.lo = p[W-1:0];
        r.hi = p[2*W-1:W];
      end
      4'b1101: begin
        if (b == 0) begin
          r.lo = '1; r.hi = a; r.dz = 1'b1;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
      default: r.lo = '0;
    endcase
    r.z = (r.lo == 0);
    return r;
  endfunction

  // Drives one accepted start and records the expected result on the scoreboard.
  // Returns at the negedge just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alu_ctr = op; R2 = a; R3 = b;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0; R2 = $urandom; R3 = $urandom;
  endtask

  // Counts edges after accept until done, with a bounded budget.
  task automatic wait_done(output int lat, output int busy_cyc, output bit overlap, output bit to);
    lat = 0; busy_cyc = 0; overlap = 1'b0; to = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cyc++;
      if (lat > W + 8) begin to = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; alu_ctr = '0; R2 = '0; R3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({alu_out, hi_out, zero, div_zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_state: got lo=%h hi=%h z=%b dz=%b busy=%b done=%b, expected all 0",
               alu_out, hi_out, zero, div_zero, busy, done);
    end
  endtask

  task automatic test_single;
    logic [3:0]   ops [12] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b0011,
                               4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    logic [W-1:0] as  [12] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'hFFFF_FFFF,
                               32'hAAAA_5555, 32'h0F0F_0000, 32'h1200_0034, 32'h0000_0003,
                               32'h8000_0000, 32'h8000_0001, 32'hDEAD_BEEF};
    logic [W-1:0] bs  [12] = '{32'd5, 32'd1, 32'd1, 32'h0FF0_FF00, 32'd2, 32'hFFFF_0000,
                               32'h00F0_F0F0, 32'h0056_0000, 32'h0000_003F, 32'd31,
                               32'h0000_0024, 32'h1234_5678};
    int lat, bc; bit ov, to;
    res_t e;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, bc, ov, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != 0 || bc != 0 || ov || {alu_out, hi_out, zero, div_zero} !== e) begin
        failures++;
        $display("FAIL single_op%0d: got lo=%h hi=%h z=%b dz=%b lat=%0d busy_cyc=%0d, expected lo=%h hi=%h z=%b dz=%b lat=0 busy_cyc=0",
                 i, alu_out, hi_out, zero, div_zero, lat, bc, e.lo, e.hi, e.z, e.dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL single_pulse%0d: done=%b, expected 0", i, done);
      end
    end
  endtask

  task automatic test_iter(input string name, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bc; bit ov, to;
    res_t e;
    issue(op, a, b);
    wait_done(lat, bc, ov, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != W || bc != W || ov || {alu_out, hi_out, zero, div_zero} !== e) begin
      failures++;
      $display("FAIL %s: got lo=%h hi=%h z=%b dz=%b lat=%0d busy_cyc=%0d ov=%b, expected lo=%h hi=%h z=%b dz=%b lat=%0d busy_cyc=%0d",
               name, alu_out, hi_out, zero, div_zero, lat, bc, ov, e.lo, e.hi, e.z, e.dz, W, W);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: done=%b busy=%b, expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_mul;
    test_iter("mul_max", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_iter("mul_zero", 4'b1100, 32'd0, 32'h123);
    test_iter("mul_rand", 4'b1100, $urandom, $urandom);
  endtask

  task automatic test_div;
    test_iter("div_100_7", 4'b1101, 32'd100, 32'd7);
    test_iter("div_3_9", 4'b1101, 32'd3, 32'd9);
    test_iter("div_max_1", 4'b1101, 32'hFFFF_FFFF, 32'd1);
    test_iter("div_rand", 4'b1101, $urandom, $urandom_range(1, 1000));
  endtask

  task automatic test_div_zero;
    int lat, bc; bit ov, to;
    res_t e;
    issue(4'b1101, 32'h1234, 32'd0);
    wait_done(lat, bc, ov, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 0 || bc != 0 || {alu_out, hi_out, zero, div_zero} !== e) begin
      failures++;
      $display("FAIL div_by_zero: got lo=%h hi=%h z=%b dz=%b lat=%0d, expected lo=%h hi=%h z=%b dz=%b lat=0",
               alu_out, hi_out, zero, div_zero, lat, e.lo, e.hi, e.z, e.dz);
    end
    issue(4'b0001, 32'd1, 32'd1);
    wait_done(lat, bc, ov, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 0 || {alu_out, hi_out, zero, div_zero} !== e) begin
      failures++;
      $display("FAIL dz_clear: got lo=%h hi=%h z=%b dz=%b, expected lo=%h hi=%h z=%b dz=%b",
               alu_out, hi_out, zero, div_zero, e.lo, e.hi, e.z, e.dz);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1101};
    res_t e;
    logic [W-1:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = (i == 3) ? 32'd0 : $urandom;
      start = 1'b1; alu_ctr = ops[i]; R2 = a; R3 = b;
      sb.push_back(model(ops[i], a, b));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {alu_out, hi_out, zero, div_zero} !== e) begin
        failures++;
        $display("FAIL b2b_%0d: got done=%b busy=%b lo=%h hi=%h z=%b dz=%b, expected done=1 busy=0 lo=%h hi=%h z=%b dz=%b",
                 i, done, busy, alu_out, hi_out, zero, div_zero, e.lo, e.hi, e.z, e.dz);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: done=%b, expected 0", done);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bc, extra; bit ov, to;
    res_t e;
    issue(4'b1100, 32'h8765_4321, 32'h0000_1F03);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_ctr = 4'b0001; R2 = 32'd1; R3 = 32'd1;
    @(negedge clk);
    start = 1'b0; R2 = 32'hFFFF_FFFF; R3 = 32'hFFFF_FFFF;
    wait_done(lat, bc, ov, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != W - 5 || {alu_out, hi_out, zero, div_zero} !== e) begin
      failures++;
      $display("FAIL busy_ignore: got lo=%h hi=%h z=%b dz=%b lat=%0d, expected lo=%h hi=%h z=%b dz=%b lat=%0d",
               alu_out, hi_out, zero, div_zero, lat, e.lo, e.hi, e.z, e.dz, W - 5);
    end
    extra = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_single: got %0d extra done/busy cycles, expected 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc, seen; bit ov, to;
    res_t e;
    issue(4'b1101, 32'hDEAD_BEEF, 32'h13);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({alu_out, hi_out, zero, div_zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_abort: got lo=%h hi=%h z=%b dz=%b busy=%b done=%b, expected all 0",
               alu_out, hi_out, zero, div_zero, busy, done);
    end
    seen = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abort_nodone: got %0d done/busy cycles, expected 0", seen);
    end
    issue(4'b1010, 32'h8000_0000, 32'd4);
    wait_done(lat, bc, ov, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 0 || {alu_out, hi_out, zero, div_zero} !== e || e.lo !== 32'hF800_0000) begin
      failures++;
      $display("FAIL sra_after_reset: got lo=%h hi=%h z=%b dz=%b, expected lo=%h hi=%h z=%b dz=%b",
               alu_out, hi_out, zero, div_zero, e.lo, e.hi, e.z, e.dz);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
